// File: rtl/fft_stage_sequencer_if.sv
// Start/stall handshake plus read- and write-side address bundle of the FFT stage sequencer.
// The sequencer takes the slave side; the controller or bench driving start/stall takes the master side.
interface fft_stage_sequencer_if #(
  parameter int CW = 6
);
  logic          start;
  logic          stall;
  logic [CW-1:0] counter_r;
  logic [2:0]    stage_num_r;
  logic          rd_en;
  logic [CW-1:0] counter_w;
  logic [2:0]    stage_num_w;
  logic          wr_en;
  logic          busy;
  logic          done;

  modport master (
    output start, stall,
    input  counter_r, stage_num_r, rd_en, counter_w, stage_num_w, wr_en, busy, done
  );

  modport slave (
    input  start, stall,
    output counter_r, stage_num_r, rd_en, counter_w, stage_num_w, wr_en, busy, done
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Pass/group sequencer for the in-place FFT: issues read addresses per pass, drains the
// butterfly pipeline between passes and replays the read side PIPE_LAT cycles later for writes.
module fft_stage_sequencer #(
  parameter int NUMSTAGES = 8,
  parameter int NUMPASSES = 5,
  parameter int PIPE_LAT  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fft_stage_sequencer_if.slave bus
);
  localparam int              CW         = NUMSTAGES - 2;
  localparam logic [CW-1:0]   CNT_MAX    = '1;
  localparam logic [2:0]      LAST_STAGE = 3'(NUMPASSES - 1);
  localparam int              DW         = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  typedef struct packed {
    logic          en;
    logic [CW-1:0] cnt;
    logic [2:0]    stg;
  } rd_beat_t;

  state_e        state_q;
  logic [CW-1:0] counter_q;
  logic [2:0]    stage_q;
  logic          rd_en_q;
  logic          busy_q;
  logic          done_q;
  logic [DW-1:0] drain_q;
  rd_beat_t      beat_d;
  rd_beat_t      pipe_q [PIPE_LAT];

  // The counter advances only after a cycle that actually issued a read, so a
  // stalled group is shown again (with rd_en low) until it is issued once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      counter_q <= '0;
      stage_q   <= '0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drain_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q   <= RUN;
            counter_q <= '0;
            stage_q   <= '0;
            rd_en_q   <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        RUN: begin
          if (rd_en_q && counter_q == CNT_MAX) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
            drain_q <= '0;
          end else begin
            if (rd_en_q) counter_q <= counter_q + 1'b1;
            rd_en_q <= ~bus.stall;
          end
        end
        DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            if (stage_q == LAST_STAGE) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= RUN;
              stage_q   <= stage_q + 1'b1;
              counter_q <= '0;
              rd_en_q   <= 1'b1;
            end
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          counter_q <= '0;
          stage_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    beat_d = '{en: rd_en_q, cnt: counter_q, stg: stage_q};
  end

  // Free-running delay line: stall bubbles and drain gaps travel through as wr_en=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= beat_d;
      for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign bus.counter_r   = counter_q;
  assign bus.stage_num_r = stage_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.wr_en       = pipe_q[PIPE_LAT-1].en;
  assign bus.counter_w   = pipe_q[PIPE_LAT-1].cnt;
  assign bus.stage_num_w = pipe_q[PIPE_LAT-1].stg;
endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
Control sequencer that sits directly upstream of address_control in the 256-point in-place FFT core. It generates counter_r and stage_num_r, which address_control turns into bank read and write addresses. It also produces the matching write-side counter and stage, delayed to line up with the butterfly datapath latency. It owns start/done handshaking and inserts a drain gap between stages so a stage never reads a location before the previous stage has written it.

Parameters:
NUMSTAGES, 8, log2(NUMSAMPLES); counter width is NUMSTAGES-2 (64 butterfly groups per pass).
NUMPASSES, 5, number of passes executed; stage_num_r runs 0..NUMPASSES-1; must be ≤ 7.
PIPE_LAT, 4, read-to-write latency of the butterfly datapath in cycles; must be ≥ 1.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a transform; sampled only in IDLE
stall  in  1  freeze read-side issue (downstream not ready)
counter_r  out  NUMSTAGES-2  read-side group counter to address_control
stage_num_r  out  3  read-side pass number to address_control
rd_en  out  1  counter_r/stage_num_r valid this cycle
counter_w  out  NUMSTAGES-2  write-side group counter (counter_r delayed PIPE_LAT)
stage_num_w  out  3  write-side pass number (stage_num_r delayed PIPE_LAT)
wr_en  out  1  rd_en delayed PIPE_LAT
busy  out  1  high in RUN, DRAIN and DONE
done  out  1  one-cycle pulse when the transform completes

Behaviour:
- Reset (rst_n low, async): state=IDLE; all outputs 0; delay pipe cleared. Reset mid-operation aborts immediately with no partial done.
- States: IDLE, RUN, DRAIN, DONE. All outputs are registered.
- IDLE: busy=0, rd_en=0. start=1 at an edge → RUN on the next cycle, with counter_r=0, stage_num_r=0, rd_en=1.
- RUN: rd_en = ~stall.
  - stall=0: counter_r increments each cycle.
  - stall=1: counter_r and stage_num_r hold, rd_en=0.
  - Issuing counter_r = 2^(NUMSTAGES-2)-1 with stall=0 → DRAIN next cycle. The counter never wraps inside RUN.
- DRAIN: rd_en=0; lasts exactly PIPE_LAT cycles; stall is ignored.
  - At exit, if stage_num_r == NUMPASSES-1 → DONE.
  - Otherwise stage_num_r+1, counter_r=0 → RUN.
- DONE: done=1 for exactly one cycle → IDLE. counter_r and stage_num_r return to 0 on entering IDLE.
- Write side: {wr_en, counter_w, stage_num_w} is a PIPE_LAT-deep shift of {rd_en, counter_r, stage_num_r}.
  - The shift runs every cycle, including stall and DRAIN.
  - Bubbles from stall propagate as wr_en=0.
  - The last write of a pass always lands in the final DRAIN cycle, before the next pass's first read.
- start while busy: ignored. start held high through DONE: a new transform starts from IDLE on the following edge (not from DONE).
- Unstalled timing, start sampled at edge k:
  - RUN occupies k+1..k+64 per pass; DRAIN occupies k+65..k+68.
  - Each pass is 64+PIPE_LAT cycles.
  - done is high in cycle k+5·68+1 = k+341.

Test Plan:
- Reset then idle, start=0 for 20 cycles → all outputs 0, busy=0.
- start pulse at cycle k, no stall → counter_r 0..63 each pass, stage_num_r 0..4. rd_en has 4-cycle gaps. wr_en/counter_w/stage_num_w match rd_en/counter_r/stage_num_r shifted 4 cycles. done pulses one cycle at k+341. Total wr_en-high cycles = 320.
- stall high for 3 cycles at counter_r=10 in pass 2, and at counter_r=63 → counter holds, rd_en=0 during stall. No counter value is skipped or duplicated on the write side. done is delayed by exactly 6 cycles.
- start asserted again during RUN and during DRAIN → no effect; a single done pulse.
- rst_n low in pass 3 mid-RUN → outputs 0 asynchronously, wr_en=0 immediately. A later start runs a full clean transform.
- Rerun with NUMPASSES=1, PIPE_LAT=1 → one pass of 64 reads; done at k+66; stage_num_w never exceeds 0.
